neopixel_rx: RTL and testbench
==============================

// Module: neopixel_rx
// PURPOSE
//  APB3 peripheral that decodes a WS2812 single-wire stream on np_in back into 24-bit pixel words.
//  Measures each high pulse in PCLK cycles, classifies it as a 0 or 1, and assembles bits MSB first.
//  Buffers completed words in a small FIFO that the processor reads over APB.
//  Used for loopback checking of the pixel transmitter and for sniffing a pixel chain.
// PARAMETERS
//  THRESH        48    high width >= THRESH cycles decodes as 1, else 0 (tx: 32 -> 0, 64 -> 1)
//  MIN_HIGH      8     high width < MIN_HIGH cycles is a glitch -> pulse error
//  MAX_HIGH      90    high width > MAX_HIGH cycles -> pulse error
//  RESET_CYCLES  4000  low time >= RESET_CYCLES cycles (50us) ends a frame
//  FIFO_DEPTH    4     word FIFO depth; power of 2, >= 2
// PORTS
//  PCLK     in   1   clock
//  PRESERN  in   1   reset; asynchronous, active-low
//  PSEL     in   1   APB select
//  PENABLE  in   1   APB access phase
//  PWRITE   in   1   APB write
//  PADDR    in   32  APB address; only PADDR[3:2] is decoded
//  PWDATA   in   32  APB write data
//  PRDATA   out  32  APB read data
//  PREADY   out  1   tied to 1
//  PSLVERR  out  1   tied to 0
//  np_in    in   1   asynchronous WS2812 data line
//  irq      out  1   level interrupt: CTRL.irq_en & fifo not empty
// BEHAVIOUR
//  Reset: all state cleared; PRDATA=0, irq=0, FIFO empty, STATUS=0, CTRL=0, FSM=SYNC.
//  np_in passes through a 2-flop synchronizer. Edge detect is on the synchronized value, so decode latency is 2-3 cycles.
//  Registers, selected by PADDR[3:2]:
//   0: DATA (RO) = {7'b0, valid, word[23:0]} from the FIFO head.
//      An access-phase read pops the head when not empty; a read when empty returns 0.
//   1: STATUS = {24'b0, count[3:0], overflow, pulse_err, frame_done, busy}.
//      Bits [3:1] are write-1-to-clear. count and busy are read-only.
//   2: CTRL = {30'b0, irq_en, enable}. bit2 = flush: writing 1 empties the FIFO; it is not stored.
//   3: reads 0; writes are ignored.
//  PRDATA is combinational from PADDR while PSEL=1; otherwise 0.
//  Writes take effect on PSEL&PENABLE&PWRITE.
//  Counter: 14 bits, saturating; cleared on every synchronized edge.
//  FSM states:
//   SYNC: wait for low time >= RESET_CYCLES, then go to IDLE. Entered at reset, when enable=0, and after any error.
//   IDLE: on a rising edge, go to HIGH with bit_cnt=0.
//   HIGH: on a falling edge, check width w.
//         If w < MIN_HIGH or w > MAX_HIGH: set pulse_err, discard the partial word, go to SYNC.
//         Otherwise shift in bit (w >= THRESH) and go to LOW. If the line stays high beyond MAX_HIGH+1 cycles, treat it as an error immediately.
//   LOW:  If bit_cnt reached 24, push the word to the FIFO and set bit_cnt=0.
//         A rising edge before RESET_CYCLES goes to HIGH.
//         Low time reaching RESET_CYCLES sets frame_done and goes to IDLE.
//         If 0 < bit_cnt < 24 at that point, also set pulse_err and discard the partial word.
//  busy = 1 in HIGH or LOW.
//  FIFO behaviour:
//   Full on push: drop the new word and set overflow; contents are unchanged.
//   Push and pop in the same cycle: both occur and count is unchanged. If empty and pushing, the pop returns empty (0) and the push still lands.
//   Flush in the same cycle as a push: flush wins and the FIFO ends empty.
//  Clearing enable mid-word aborts it silently (no error) and returns to SYNC. FIFO contents are kept.
//  Async reset mid-frame: everything clears immediately. After release, a new SYNC gap is needed before decoding.
// TESTING
//  1. enable=1; 4000 low cycles; send 24 bits of 0xA5C30F (high 64/low 34 for 1, 32/68 for 0); then 4000 low.
//     -> DATA read = 0x01A5C30F; frame_done=1; then DATA read = 0; count=0.
//  2. Send 5 frames of 24 bits with FIFO_DEPTH=4 and no reads.
//     -> count=4; overflow=1; the 4 reads return the first 4 words in order.
//  3. Inject a 5-cycle high pulse at bit 10.
//     -> pulse_err=1; no push; the next valid frame after a 4000-cycle gap decodes correctly.
//  4. Send 12 bits, then 4000 low.
//     -> pulse_err=1, frame_done=1, FIFO empty. W1C write 0x0E to STATUS -> bits clear.
//  5. Read DATA in the same cycle the 24th bit's LOW push occurs, with 1 word already held.
//     -> the old word is returned; count stays 1.
//  6. irq_en=1 -> irq rises the cycle after the push. Flush -> irq=0.
//     Assert PRESERN low mid-word -> all outputs 0 at once.

Source files
------------

// File: rtl/neopixel_rx.sv
// neopixel_rx: APB3 peripheral that decodes a WS2812 single-wire stream into 24-bit pixel words.
// Pulse widths are measured in PCLK cycles; completed words land in a small FIFO read over APB.
module neopixel_rx #(
    parameter int THRESH       = 48,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 90,
    parameter int RESET_CYCLES = 4000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        np_in,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_np_s1, r_np_s2, r_np_d;
    logic          w_rise, w_fall;
    logic [13:0]   r_cnt;
    logic [14:0]   w_width;
    logic          w_low_done;

    logic [4:0]    r_bitcnt;
    logic [23:0]   r_shift;
    logic          w_shift_en, w_bit, w_bitcnt_clr, w_push, w_set_perr, w_set_fdone;

    logic          r_enable, r_irq_en;
    logic          r_ovf, r_perr, r_fdone;

    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full, w_empty, w_push_ok, w_pop, w_flush, w_ovf_set;

    logic          w_wr, w_rd, w_w1c, w_ctrl_wr;
    logic [1:0]    w_sel;
    logic          w_busy;
    logic          w_unused;

    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign w_unused = &{1'b0, PADDR[31:4], PADDR[1:0], PWDATA[31:4]};

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_np_s1 <= 1'b0;
            r_np_s2 <= 1'b0;
            r_np_d  <= 1'b0;
        end else begin
            r_np_s1 <= np_in;
            r_np_s2 <= r_np_s1;
            r_np_d  <= r_np_s2;
        end
    end

    assign w_rise = r_np_s2 & ~r_np_d;
    assign w_fall = ~r_np_s2 & r_np_d;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= '0;
        end else if (r_cnt != 14'h3FFF) begin
            r_cnt <= r_cnt + 14'd1;
        end
    end

    // Width of the level that has just ended (or has lasted so far) including this cycle.
    assign w_width    = {1'b0, r_cnt} + 15'd1;
    assign w_low_done = ~r_np_s2 & ~w_fall & (w_width >= 15'(RESET_CYCLES));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_en   = 1'b0;
        w_bit        = (w_width >= 15'(THRESH));
        w_bitcnt_clr = 1'b0;
        w_push       = 1'b0;
        w_set_perr   = 1'b0;
        w_set_fdone  = 1'b0;
        if (!r_enable) begin
            w_state_nxt  = S_SYNC;
            w_bitcnt_clr = 1'b1;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_low_done) w_state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt  = S_HIGH;
                        w_bitcnt_clr = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        if ((w_width < 15'(MIN_HIGH)) || (w_width > 15'(MAX_HIGH))) begin
                            w_set_perr  = 1'b1;
                            w_state_nxt = S_SYNC;
                        end else begin
                            w_shift_en  = 1'b1;
                            w_state_nxt = S_LOW;
                        end
                    end else if (w_width > 15'(MAX_HIGH + 1)) begin
                        w_set_perr  = 1'b1;
                        w_state_nxt = S_SYNC;
                    end
                end
                S_LOW: begin
                    if (r_bitcnt == 5'd24) begin
                        w_push       = 1'b1;
                        w_bitcnt_clr = 1'b1;
                    end
                    if (w_rise) begin
                        w_state_nxt = S_HIGH;
                    end else if (w_low_done) begin
                        w_set_fdone  = 1'b1;
                        w_bitcnt_clr = 1'b1;
                        w_state_nxt  = S_IDLE;
                        if ((r_bitcnt != 5'd0) && (r_bitcnt != 5'd24)) w_set_perr = 1'b1;
                    end
                end
                default: w_state_nxt = S_SYNC;
            endcase
        end
    end

    // Bits arrive MSB first; a partial word is discarded by simply restarting bit_cnt.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            if (w_bitcnt_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 5'd1;
            end
            if (w_shift_en) r_shift <= {r_shift[22:0], w_bit};
        end
    end

    assign w_busy    = (r_state == S_HIGH) || (r_state == S_LOW);
    assign w_sel     = PADDR[3:2];
    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_rd      = PSEL & PENABLE & ~PWRITE;
    assign w_w1c     = w_wr & (w_sel == 2'd1);
    assign w_ctrl_wr = w_wr & (w_sel == 2'd2);

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_flush   = w_ctrl_wr & PWDATA[2];
    assign w_pop     = w_rd & (w_sel == 2'd0) & ~w_empty;
    assign w_push_ok = w_push & ~w_full;
    assign w_ovf_set = w_push & w_full & ~w_flush;

    // Flush overrides any push or pop landing in the same cycle.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push_ok && !w_flush) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_fdone  <= 1'b0;
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_ovf   <= w_ovf_set   | (r_ovf   & ~(w_w1c & PWDATA[3]));
            r_perr  <= w_set_perr  | (r_perr  & ~(w_w1c & PWDATA[2]));
            r_fdone <= w_set_fdone | (r_fdone & ~(w_w1c & PWDATA[1]));
            if (w_ctrl_wr) begin
                r_enable <= PWDATA[0];
                r_irq_en <= PWDATA[1];
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (w_sel)
                2'd0:    if (!w_empty) PRDATA = {7'b0, 1'b1, r_mem[r_rptr]};
                2'd1:    PRDATA = {24'b0, 4'(r_count), r_ovf, r_perr, r_fdone, w_busy};
                2'd2:    PRDATA = {30'b0, r_irq_en, r_enable};
                default: PRDATA = '0;
            endcase
        end
    end

    assign irq = r_irq_en & ~w_empty;

endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: directed bench driving WS2812 waveforms and APB accesses into neopixel_rx.
// Expected register values are hand-computed from the decoded pixel words.
module tb_neopixel_rx;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        np_in = 1'b0;
    logic        irq;

    int          vecCount = 0;
    int          missCount = 0;
    logic [31:0] probeExpect = '0;
    logic [31:0] rd;

    localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_CTRL = 32'h8;

    neopixel_rx dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .np_in   (np_in),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge PCLK);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // One WS2812 bit. probe 1: APB DATA read whose access phase hits the push cycle of this bit;
    // probe 2: sample irq on either side of that push.
    task automatic applyStimulus(input logic b, input int probe);
        int hi, lo;
        hi = b ? 64 : 32;
        lo = b ? 34 : 68;
        @(posedge PCLK);
        #1 np_in = 1'b1;
        repeat (hi) @(posedge PCLK);
        #1 np_in = 1'b0;
        if (probe == 1) begin
            repeat (3) @(negedge PCLK);
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_DATA;
            @(negedge PCLK);
            PENABLE = 1'b1;
            #1 checkOutput("read during push", PRDATA, probeExpect);
            @(posedge PCLK);
            @(negedge PCLK);
            PSEL = 1'b0; PENABLE = 1'b0;
            repeat (lo - 5) @(posedge PCLK);
        end else if (probe == 2) begin
            repeat (4) @(negedge PCLK);
            checkOutput("irq before push", {31'b0, irq}, 32'h0);
            @(negedge PCLK);
            checkOutput("irq after push", {31'b0, irq}, 32'h1);
            repeat (lo - 6) @(posedge PCLK);
        end else begin
            repeat (lo - 1) @(posedge PCLK);
        end
    endtask

    task automatic sendBits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) applyStimulus(w[23 - i], 0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge PCLK);
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        #1 checkOutput("prdata idle in reset", PRDATA, 32'h0);
        PRESERN = 1'b1;

        // Reset state
        apbRead(A_STATUS, rd); checkOutput("reset status", rd, 32'h0);
        apbRead(A_CTRL, rd);   checkOutput("reset ctrl", rd, 32'h0);
        apbRead(A_DATA, rd);   checkOutput("reset data", rd, 32'h0);
        checkOutput("reset irq", {31'b0, irq}, 32'h0);

        // Single frame decode
        apbWrite(A_CTRL, 32'h1);
        gap(4010);
        sendBits(24'hA5C30F, 24);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t1 status", rd, 32'h12);
        apbRead(A_DATA, rd);   checkOutput("t1 data", rd, 32'h01A5C30F);
        apbRead(A_DATA, rd);   checkOutput("t1 data empty", rd, 32'h0);
        apbRead(A_STATUS, rd); checkOutput("t1 status after pop", rd, 32'h02);
        apbWrite(A_STATUS, 32'h0E);
        apbRead(A_STATUS, rd); checkOutput("t1 w1c", rd, 32'h0);

        // Five back-to-back words into a depth-4 FIFO
        sendBits(24'h123456, 24);
        sendBits(24'hABCDEF, 24);
        sendBits(24'h000001, 24);
        sendBits(24'hFFFFFE, 24);
        sendBits(24'h5A5A5A, 24);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t2 status full", rd, 32'h4A);
        apbRead(A_DATA, rd);   checkOutput("t2 word0", rd, 32'h01123456);
        apbRead(A_DATA, rd);   checkOutput("t2 word1", rd, 32'h01ABCDEF);
        apbRead(A_DATA, rd);   checkOutput("t2 word2", rd, 32'h01000001);
        apbRead(A_DATA, rd);   checkOutput("t2 word3", rd, 32'h01FFFFFE);
        apbRead(A_DATA, rd);   checkOutput("t2 drained", rd, 32'h0);
        apbWrite(A_STATUS, 32'h0E);
        apbRead(A_STATUS, rd); checkOutput("t2 w1c", rd, 32'h0);

        // Glitch pulse at bit 10, then recovery
        sendBits(24'h3C96E1, 10);
        @(posedge PCLK);
        #1 np_in = 1'b1;
        repeat (5) @(posedge PCLK);
        #1 np_in = 1'b0;
        gap(50);
        apbRead(A_STATUS, rd); checkOutput("t3 glitch status", rd, 32'h04);
        gap(4010);
        sendBits(24'h3C96E1, 24);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t3 status", rd, 32'h16);
        apbRead(A_DATA, rd);   checkOutput("t3 data", rd, 32'h013C96E1);
        apbWrite(A_STATUS, 32'h0E);

        // Truncated frame
        sendBits(24'hFFF000, 12);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t4 short frame", rd, 32'h06);
        apbWrite(A_STATUS, 32'h0E);
        apbRead(A_STATUS, rd); checkOutput("t4 w1c", rd, 32'h0);

        // Pop coinciding with push, then irq and flush
        sendBits(24'h0F0F0F, 24);
        gap(4010);
        apbWrite(A_STATUS, 32'h0E);
        probeExpect = 32'h010F0F0F;
        sendBits(24'h800001, 23);
        applyStimulus(1'b1, 1);
        apbRead(A_STATUS, rd); checkOutput("t5 count kept", rd, 32'h11);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t5 status", rd, 32'h12);
        apbWrite(A_CTRL, 32'h3);
        checkOutput("t5 irq with data", {31'b0, irq}, 32'h1);
        apbWrite(A_CTRL, 32'h7);
        checkOutput("t5 irq after flush", {31'b0, irq}, 32'h0);
        apbRead(A_CTRL, rd);   checkOutput("t5 flush not stored", rd, 32'h3);
        apbRead(A_DATA, rd);   checkOutput("t5 data after flush", rd, 32'h0);
        apbWrite(A_STATUS, 32'h0E);

        // irq timing, then reset mid-word
        checkOutput("t6 irq empty", {31'b0, irq}, 32'h0);
        sendBits(24'h00FF00, 23);
        applyStimulus(1'b0, 2);
        sendBits(24'hC30000, 8);
        @(posedge PCLK);
        #1 np_in = 1'b1;
        gap(20);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_STATUS;
        #1 checkOutput("t6 busy mid-word", PRDATA, 32'h11);
        PRESERN = 1'b0;
        #1 checkOutput("t6 prdata in reset", PRDATA, 32'h0);
        checkOutput("t6 irq in reset", {31'b0, irq}, 32'h0);
        np_in = 1'b0;
        PSEL = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESERN = 1'b1;
        apbWrite(A_CTRL, 32'h1);
        sendBits(24'h777777, 24);
        gap(4010);
        apbRead(A_STATUS, rd); checkOutput("t6 no decode without gap", rd, 32'h0);
        apbRead(A_DATA, rd);   checkOutput("t6 fifo empty", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
